// File: rtl/imm_encode_if.sv
// Request/response bundle for the immediate encoder.
// The master side issues instruction fields and consumes encoded words;
// the slave side is the encoder itself.
interface imm_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  modport master (
    output in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err, enc_count, err_count
  );

  modport slave (
    input  in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err, enc_count, err_count
  );
endinterface

// File: rtl/imm_encode_unit.sv
// Packs RISC-V instruction fields plus an immediate into a 32-bit word.
// One-deep output register with valid/ready on both sides; range or
// alignment problems are flagged on out_err while the truncated word is
// still emitted. Illegal types produce a NOP with out_err set.
module imm_encode_unit (
  input  logic         clk,
  input  logic         rst,
  imm_encode_if.slave  bus
);

  localparam logic [2:0]  T_RTYPE = 3'd0;
  localparam logic [2:0]  T_ITYPE = 3'd1;
  localparam logic [2:0]  T_STYPE = 3'd2;
  localparam logic [2:0]  T_BTYPE = 3'd3;
  localparam logic [2:0]  T_UTYPE = 3'd4;
  localparam logic [2:0]  T_JTYPE = 3'd5;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_err_q,   out_err_d;
  logic [15:0] enc_count_q, enc_count_d;
  logic [7:0]  err_count_q, err_count_d;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        fits_12, fits_13, fits_21;
  logic        in_ready;
  logic        in_fire;
  logic        out_fire;

  // The register can take a new word when empty or when it drains this cycle.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = out_valid_q && bus.out_ready;

  // Pack the word for the requested format and decide whether it is in error.
  always_comb begin
    // A signed immediate fits N bits when every bit from N-1 upward matches.
    fits_12  = (&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]);
    fits_13  = (&bus.in_imm[31:12]) || !(|bus.in_imm[31:12]);
    fits_21  = (&bus.in_imm[31:20]) || !(|bus.in_imm[31:20]);
    enc_word = NOP_WORD;
    enc_err  = 1'b1;
    case (bus.in_type)
      T_RTYPE: begin
        enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    bus.in_rd, bus.in_opcode};
        enc_err  = 1'b0;
      end
      T_ITYPE: begin
        enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                    bus.in_rd, bus.in_opcode};
        enc_err  = !fits_12;
      end
      T_STYPE: begin
        enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    bus.in_imm[4:0], bus.in_opcode};
        enc_err  = !fits_12;
      end
      T_BTYPE: begin
        enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                    bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11],
                    bus.in_opcode};
        enc_err  = !fits_13 || bus.in_imm[0];
      end
      T_UTYPE: begin
        enc_word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
        enc_err  = |bus.in_imm[11:0];
      end
      T_JTYPE: begin
        enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                    bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
        enc_err  = !fits_21 || bus.in_imm[0];
      end
      default: begin
        enc_word = NOP_WORD;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Next-state for the output register and the statistics counters.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_instr_d = enc_word;
      out_err_d   = enc_err;
      enc_count_d = enc_count_q + 16'd1;
      if (enc_err && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset wins over any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_err_q   <= 1'b0;
      enc_count_q <= 16'd0;
      err_count_q <= 8'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_err   = out_err_q;
  assign bus.enc_count = enc_count_q;
  assign bus.err_count = err_count_q;

endmodule
